ring_decoder: RTL and testbench

RING_DECODER -- requirements
Module: ring_decoder

---
 rtl/ring_decoder.sv | 147 ++++++++++++++
 tb/tb_ring_decoder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ring_decoder.sv
// Ring-counter decoder: HUNT/TRACK/LOCKED sequence checker; optional err_count via RING_DECODER_ERR_CNT_EN.
// Latency 1 (all outputs registered); no backpressure, code is consumed only when code_valid is high.
module ring_decoder #(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         code,
    input  logic                     code_valid,
    output logic [$clog2(WIDTH)-1:0] index,
    output logic                     idx_valid,
    output logic                     locked,
    output logic                     err,
    output logic [7:0]               err_count
);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] expected_q, expected_d;
    logic [7:0]       count_q, count_d;
    logic [IW-1:0]    index_q, index_d;
    logic             idx_valid_q, idx_valid_d;
    logic             err_q, err_d;

    logic             is_onehot;
    logic [IW-1:0]    enc_idx;
    logic [WIDTH-1:0] succ;
    logic             is_expected;
    logic [8:0]       count_inc;

    always_comb begin
        enc_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (code[i]) enc_idx = IW'(i);
        end
    end

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign is_onehot   = (code != '0) && ((code & (code - 1'b1)) == '0);
    assign succ        = {code[0], code[WIDTH-1:1]};
    assign is_expected = is_onehot && (code == expected_q);
    assign count_inc   = {1'b0, count_q} + 9'd1;

    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        count_d     = count_q;
        index_d     = index_q;
        idx_valid_d = 1'b0;
        err_d       = 1'b0;

        if (code_valid) begin
            if (is_onehot) begin
                idx_valid_d = 1'b1;
                index_d     = enc_idx;
            end
            case (state_q)
                HUNT: begin
                    if (is_onehot) begin
                        count_d    = 8'd1;
                        expected_d = succ;
                        state_d    = (LOCK_COUNT == 1) ? LOCKED : TRACK;
                    end
                end
                TRACK: begin
                    if (is_expected) begin
                        expected_d = succ;
                        if (count_inc >= 9'(LOCK_COUNT)) begin
                            count_d = 8'(LOCK_COUNT);
                            state_d = LOCKED;
                        end else begin
                            count_d = count_inc[7:0];
                        end
                    end else if (is_onehot) begin
                        count_d    = 8'd1;
                        expected_d = succ;
                    end else begin
                        count_d = 8'd0;
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    if (is_expected) begin
                        expected_d = succ;
                    end else begin
                        err_d   = 1'b1;
                        count_d = 8'd0;
                        state_d = HUNT;
                    end
                end
                default: begin
                    count_d = 8'd0;
                    state_d = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= HUNT;
            expected_q  <= '0;
            count_q     <= 8'd0;
            index_q     <= '0;
            idx_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            count_q     <= count_d;
            index_q     <= index_d;
            idx_valid_q <= idx_valid_d;
            err_q       <= err_d;
        end
    end

    assign index     = index_q;
    assign idx_valid = idx_valid_q;
    assign locked    = (state_q == LOCKED);
    assign err       = err_q;

`ifdef RING_DECODER_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) err_cnt_q <= 8'd0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_ring_decoder.sv
// Directed bench for ring_decoder (WIDTH=4, LOCK_COUNT=4); expectations follow RING_DECODER_ERR_CNT_EN.
module tb_ring_decoder;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] code;
    logic       code_valid;
    logic [1:0] index;
    logic       idx_valid;
    logic       locked;
    logic       err;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;
    int exp_errs = 0;

    ring_decoder #(.WIDTH(4), .LOCK_COUNT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .code       (code),
        .code_valid (code_valid),
        .index      (index),
        .idx_valid  (idx_valid),
        .locked     (locked),
        .err        (err),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply inputs away from the active edge, then sample 1 time unit after it.
    task automatic step(input logic rst_n, input logic vld, input logic [3:0] c);
        @(negedge clk);
        reset      = rst_n;
        code_valid = vld;
        code       = c;
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input string tag, input logic [3:0] c, input logic e_iv,
                        input logic [1:0] e_idx, input logic e_lk, input logic e_err);
        step(1'b1, 1'b1, c);
        chk({tag, ".idx_valid"}, 32'(idx_valid), 32'(e_iv));
        if (e_iv) chk({tag, ".index"}, 32'(index), 32'(e_idx));
        chk({tag, ".locked"}, 32'(locked), 32'(e_lk));
        chk({tag, ".err"}, 32'(err), 32'(e_err));
    endtask

    function automatic logic [7:0] exp_cnt(input int n);
`ifdef RING_DECODER_ERR_CNT_EN
        return (n > 255) ? 8'd255 : 8'(n);
`else
        return 8'd0 + 8'(n - n);
`endif
    endfunction

    initial begin
        reset = 1'b0; code_valid = 1'b1; code = 4'b0101;
        step(1'b0, 1'b1, 4'b0101);
        step(1'b0, 1'b1, 4'b0011);
        chk("rst.index", 32'(index), 0);
        chk("rst.idx_valid", 32'(idx_valid), 0);
        chk("rst.locked", 32'(locked), 0);
        chk("rst.err", 32'(err), 0);
        chk("rst.err_count", 32'(err_count), 0);

        // Basic lock sequence
        feed("seq0", 4'b0001, 1, 2'd0, 0, 0);
        feed("seq1", 4'b1000, 1, 2'd3, 0, 0);
        feed("seq2", 4'b0100, 1, 2'd2, 0, 0);
        feed("seq3", 4'b0010, 1, 2'd1, 1, 0);
        feed("lk0", 4'b0001, 1, 2'd0, 1, 0);
        feed("lk1", 4'b1000, 1, 2'd3, 1, 0);

        // Mismatch while locked: 0001 when 0100 expected
        feed("mis", 4'b0001, 1, 2'd0, 0, 1);
        exp_errs++;
        chk("mis.err_count", 32'(err_count), 32'(exp_cnt(exp_errs)));
        step(1'b1, 1'b0, 4'b0100);
        chk("mis.err_pulse_end", 32'(err), 0);
        chk("idle.idx_valid", 32'(idx_valid), 0);
        chk("idle.index_hold", 32'(index), 0);

        // Illegal codes in HUNT
        feed("hunt_0011", 4'b0011, 0, 2'd0, 0, 0);
        feed("hunt_0000", 4'b0000, 0, 2'd0, 0, 0);
        chk("hunt.index_hold", 32'(index), 0);

        // Illegal 0011 in TRACK -> HUNT; a stuck TRACK would lock one code early
        feed("trk_a", 4'b0100, 1, 2'd2, 0, 0);
        feed("trk_0011", 4'b0011, 0, 2'd0, 0, 0);
        feed("trk_b0", 4'b0010, 1, 2'd1, 0, 0);
        feed("trk_b1", 4'b0001, 1, 2'd0, 0, 0);
        feed("trk_b2", 4'b1000, 1, 2'd3, 0, 0);
        feed("trk_b3", 4'b0100, 1, 2'd2, 1, 0);

        // Illegal 0000 while locked -> err
        feed("lk_0000", 4'b0000, 0, 2'd0, 0, 1);
        exp_errs++;
        chk("lk_0000.err_count", 32'(err_count), 32'(exp_cnt(exp_errs)));

        // Illegal 0000 in TRACK -> HUNT, no err
        feed("trk_c", 4'b0001, 1, 2'd0, 0, 0);
        feed("trk_0000", 4'b0000, 0, 2'd0, 0, 0);
        feed("trk_d0", 4'b1000, 1, 2'd3, 0, 0);
        feed("trk_d1", 4'b0100, 1, 2'd2, 0, 0);
        feed("trk_d2", 4'b0010, 1, 2'd1, 0, 0);
        feed("trk_d3", 4'b0001, 1, 2'd0, 1, 0);

        // Unexpected one-hot in LOCKED, then pause test from HUNT
        feed("lk_mis", 4'b0010, 1, 2'd1, 0, 1);
        exp_errs++;
        feed("p0", 4'b0001, 1, 2'd0, 0, 0);
        feed("p1", 4'b1000, 1, 2'd3, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 4'b0011);
            chk("pause.idx_valid", 32'(idx_valid), 0);
            chk("pause.locked", 32'(locked), 0);
            chk("pause.err", 32'(err), 0);
            chk("pause.index_hold", 32'(index), 3);
        end
        feed("p2", 4'b0100, 1, 2'd2, 0, 0);
        feed("p3", 4'b0010, 1, 2'd1, 1, 0);

        // Reset while locked with a mismatching code presented
        step(1'b0, 1'b1, 4'b0100);
        chk("rstlk.err", 32'(err), 0);
        chk("rstlk.locked", 32'(locked), 0);
        chk("rstlk.idx_valid", 32'(idx_valid), 0);
        chk("rstlk.index", 32'(index), 0);
        chk("rstlk.err_count", 32'(err_count), 0);
        exp_errs = 0;
        feed("post_rst", 4'b0001, 1, 2'd0, 0, 0);

        // 300 forced errors: relock then break each time
        step(1'b1, 1'b0, 4'b0000);
        for (int n = 0; n < 300; n++) begin
            step(1'b1, 1'b1, 4'b0001);
            step(1'b1, 1'b1, 4'b1000);
            step(1'b1, 1'b1, 4'b0100);
            step(1'b1, 1'b1, 4'b0010);
            if (n == 0) chk("sat.relock", 32'(locked), 1);
            step(1'b1, 1'b1, 4'b1111);
            exp_errs++;
            if (n == 0 || n == 254 || n == 299) begin
                chk("sat.err", 32'(err), 1);
                chk("sat.err_count", 32'(err_count), 32'(exp_cnt(exp_errs)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
